// File: rtl/code_lock_ctrl.sv
// Keypad code-lock controller: checks a DIGITS-long keyed code against seq and
// drives the door-open and alarm outputs with retry counting, lockout and inter-key timeout.
module code_lock_ctrl #(
    parameter int unsigned DIGITS      = 8,
    parameter int unsigned DIGIT_W     = 4,
    parameter int unsigned MAX_TRIES   = 3,
    parameter int unsigned OPEN_CYCLES = 1000,
    parameter int unsigned LOCK_CYCLES = 5000,
    parameter int unsigned KEY_TIMEOUT = 2000
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              key_valid,
    input  logic [DIGIT_W-1:0]                key_digit,
    input  logic                              key_clear,
    input  logic [DIGITS*DIGIT_W-1:0]         seq,
    output logic [2:0]                        state,
    output logic                              open,
    output logic                              alarm,
    output logic [$clog2(DIGITS)-1:0]         digit_idx,
    output logic [$clog2(MAX_TRIES+1)-1:0]    fail_cnt
);

    localparam int unsigned IDX_W    = $clog2(DIGITS);
    localparam int unsigned FAIL_W   = $clog2(MAX_TRIES + 1);
    localparam int unsigned HOLD_MAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
    localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);
    localparam int unsigned KT_W     = $clog2(KEY_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ENTRY = 3'd1,
        S_CHECK = 3'd2,
        S_OPEN  = 3'd3,
        S_ALARM = 3'd4
    } state_t;

    state_t              st;
    logic                err;
    logic [KT_W-1:0]     key_timer;
    logic [HOLD_W-1:0]   hold_timer;
    logic [DIGIT_W-1:0]  exp_digit_c;
    logic                first_bad_c;
    logic                digit_bad_c;
    logic                last_digit_c;

    assign state = st;

    // Code field selected by the number of digits already accepted; field 0 is the MS field.
    always_comb begin
        exp_digit_c = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (digit_idx == IDX_W'(i)) begin
                exp_digit_c = seq[(int'(DIGITS) - 1 - i) * int'(DIGIT_W) +: DIGIT_W];
            end
        end
    end

    assign first_bad_c  = key_digit != seq[DIGITS*DIGIT_W-1 -: DIGIT_W];
    assign digit_bad_c  = key_digit != exp_digit_c;
    assign last_digit_c = digit_idx == IDX_W'(DIGITS - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= S_IDLE;
            open       <= 1'b0;
            alarm      <= 1'b0;
            digit_idx  <= '0;
            fail_cnt   <= '0;
            err        <= 1'b0;
            key_timer  <= '0;
            hold_timer <= '0;
        end else begin
            case (st)
                S_IDLE: begin
                    // Clear beats a simultaneous key, so nothing is started.
                    if (key_clear) begin
                        digit_idx <= '0;
                        err       <= 1'b0;
                    end else if (key_valid) begin
                        err       <= first_bad_c;
                        digit_idx <= IDX_W'(1);
                        key_timer <= '0;
                        st        <= S_ENTRY;
                    end
                end

                S_ENTRY: begin
                    if (key_clear) begin
                        st        <= S_IDLE;
                        digit_idx <= '0;
                        err       <= 1'b0;
                        key_timer <= '0;
                    end else if (key_valid) begin
                        // Errors stay sticky so the failing position is never revealed early.
                        key_timer <= '0;
                        if (digit_bad_c) begin
                            err <= 1'b1;
                        end
                        if (last_digit_c) begin
                            digit_idx <= '0;
                            st        <= S_CHECK;
                        end else begin
                            digit_idx <= digit_idx + IDX_W'(1);
                        end
                    end else if (key_timer == KT_W'(KEY_TIMEOUT - 1)) begin
                        st        <= S_IDLE;
                        digit_idx <= '0;
                        err       <= 1'b0;
                        key_timer <= '0;
                    end else begin
                        key_timer <= key_timer + KT_W'(1);
                    end
                end

                S_CHECK: begin
                    hold_timer <= '0;
                    err        <= 1'b0;
                    if (!err) begin
                        st       <= S_OPEN;
                        open     <= 1'b1;
                        fail_cnt <= '0;
                    end else if (fail_cnt >= FAIL_W'(MAX_TRIES - 1)) begin
                        st       <= S_ALARM;
                        alarm    <= 1'b1;
                        fail_cnt <= FAIL_W'(MAX_TRIES);
                    end else begin
                        st       <= S_IDLE;
                        fail_cnt <= fail_cnt + FAIL_W'(1);
                    end
                end

                S_OPEN: begin
                    if (hold_timer == HOLD_W'(OPEN_CYCLES - 1)) begin
                        st         <= S_IDLE;
                        open       <= 1'b0;
                        hold_timer <= '0;
                    end else begin
                        hold_timer <= hold_timer + HOLD_W'(1);
                    end
                end

                S_ALARM: begin
                    // Lockout: keys ignored until the timer expires and the retry count is forgiven.
                    if (hold_timer == HOLD_W'(LOCK_CYCLES - 1)) begin
                        st         <= S_IDLE;
                        alarm      <= 1'b0;
                        fail_cnt   <= '0;
                        hold_timer <= '0;
                    end else begin
                        hold_timer <= hold_timer + HOLD_W'(1);
                    end
                end

                default: begin
                    st    <= S_IDLE;
                    open  <= 1'b0;
                    alarm <= 1'b0;
                end
            endcase
        end
    end

endmodule
